// File: rtl/fact_scheduler.sv
// rtl/fact_scheduler.sv - round-robin arbiter sharing one factorial core among NREQ requesters
// Optional watchdog: define FACT_SCHED_TIMEOUT_EN.
module fact_scheduler #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int NW      = 4,
    parameter int FW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*NW-1:0] n_flat,
    output logic [NREQ-1:0]    ack,
    output logic [FW-1:0]      result,
    output logic [IDW-1:0]     res_id,
    output logic               err,
    output logic               busy,
    output logic               core_start,
    output logic [NW-1:0]      core_n,
    input  logic               core_done,
    input  logic [FW-1:0]      core_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  cur_id_q, cur_id_d;
    logic [NW-1:0]   core_n_q, core_n_d;
    logic            core_start_q, core_start_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [FW-1:0]   result_q, result_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            busy_q, busy_d;
    logic            err_d;

    logic            gnt_found;
    logic [IDW-1:0]  gnt_id;
    logic [IDW-1:0]  gnt_next;

`ifdef FACT_SCHED_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_hit;
    logic          err_q;
    assign tmo_hit = (tmo_cnt_q == TW'(TIMEOUT - 1));
`endif

    // Rotating priority: first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int i = 0; i < NREQ; i++) begin
            automatic int idx = int'(ptr_q) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'(idx);
            end
        end
    end

    always_comb begin
        automatic int nxt = int'(gnt_id) + 1;
        if (nxt >= NREQ) nxt = 0;
        gnt_next = IDW'(nxt);
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cur_id_d     = cur_id_q;
        core_n_d     = core_n_q;
        core_start_d = 1'b0;
        ack_d        = '0;
        result_d     = result_q;
        res_id_d     = res_id_q;
        err_d        = 1'b0;
`ifdef FACT_SCHED_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Gating on core_done keeps a new start off a core still finishing a job.
                if (gnt_found && core_done) begin
                    state_d      = S_ISSUE;
                    cur_id_d     = gnt_id;
                    core_n_d     = n_flat[int'(gnt_id)*NW +: NW];
                    ptr_d        = gnt_next;
                    core_start_d = 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
`ifdef FACT_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT_BUSY: begin
`ifdef FACT_SCHED_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (tmo_hit) begin
                    state_d         = S_RESP;
                    result_d        = '0;
                    res_id_d        = cur_id_q;
                    ack_d[cur_id_q] = 1'b1;
                    err_d           = 1'b1;
                end else if (!core_done) begin
                    state_d = S_WAIT_DONE;
                end
`else
                if (!core_done) state_d = S_WAIT_DONE;
`endif
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    state_d         = S_RESP;
                    result_d        = core_result;
                    res_id_d        = cur_id_q;
                    ack_d[cur_id_q] = 1'b1;
                end
`ifdef FACT_SCHED_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (tmo_hit) begin
                        state_d         = S_RESP;
                        result_d        = '0;
                        res_id_d        = cur_id_q;
                        ack_d[cur_id_q] = 1'b1;
                        err_d           = 1'b1;
                    end
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cur_id_q     <= '0;
            core_n_q     <= '0;
            core_start_q <= 1'b0;
            ack_q        <= '0;
            result_q     <= '0;
            res_id_q     <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cur_id_q     <= cur_id_d;
            core_n_q     <= core_n_d;
            core_start_q <= core_start_d;
            ack_q        <= ack_d;
            result_q     <= result_d;
            res_id_q     <= res_id_d;
            busy_q       <= busy_d;
        end
    end

`ifdef FACT_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
    logic unused_err;
    assign unused_err = err_d;
`endif

    assign ack        = ack_q;
    assign result     = result_q;
    assign res_id     = res_id_q;
    assign busy       = busy_q;
    assign core_start = core_start_q;
    assign core_n     = core_n_q;

endmodule

// File: tb/tb_fact_scheduler.sv
// tb/tb_fact_scheduler.sv - directed self-checking bench for fact_scheduler with a behavioural core
module tb_fact_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] n_flat = '0;
    logic [3:0]  ack;
    logic [31:0] result;
    logic [1:0]  res_id;
    logic        err;
    logic        busy;
    logic        core_start;
    logic [3:0]  core_n;
    logic        core_done;
    logic [31:0] core_result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fact_scheduler #(
        .NREQ(4), .IDW(2), .NW(4), .FW(32), .TIMEOUT(10)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .n_flat(n_flat),
        .ack(ack), .result(result), .res_id(res_id), .err(err), .busy(busy),
        .core_start(core_start), .core_n(core_n),
        .core_done(core_done), .core_result(core_result)
    );

    // Behavioural core: done drops after start, stays low n+1 cycles, then presents n!.
    logic       done_r;
    logic [3:0] cn;
    int         ccnt;
    logic       hang = 1'b0;

    function automatic logic [31:0] fact(input logic [3:0] n);
        logic [31:0] f = 32'd1;
        for (int k = 2; k <= int'(n); k++) f = f * 32'(k);
        return f;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r      <= 1'b1;
            core_result <= '0;
            ccnt        <= 0;
            cn          <= '0;
        end else if (done_r && core_start) begin
            done_r <= 1'b0;
            cn     <= core_n;
            ccnt   <= int'(core_n) + 1;
        end else if (!done_r && !hang && ccnt > 0) begin
            if (ccnt == 1) begin
                done_r      <= 1'b1;
                core_result <= fact(cn);
            end
            ccnt <= ccnt - 1;
        end
    end
    assign core_done = done_r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_res_id"}, 32'(res_id), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_core_start"}, 32'(core_start), 0);
        chk({tag, "_core_n"}, 32'(core_n), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic wait_ack(input int budget, output int starts, output int cyc, output logic ok);
        starts = 0;
        cyc    = 0;
        ok     = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cyc++;
            if (core_start) starts++;
            if (ack != 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Waits for one job's ack, checks it, drops that requester and checks the ack is one cycle.
    task automatic job(input string tag, input logic [3:0] exp_ack, input logic [31:0] exp_res,
                       input logic [1:0] exp_id, input int exp_starts);
        int   starts;
        int   cyc;
        logic ok;
        wait_ack(200, starts, cyc, ok);
        chk({tag, "_ack_seen"}, 32'(ok), 1);
        chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_res_id"}, 32'(res_id), 32'(exp_id));
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_busy_in_resp"}, 32'(busy), 1);
        if (exp_starts >= 0) chk({tag, "_start_width"}, 32'(starts), 32'(exp_starts));
        req = req & ~exp_ack;
        @(negedge clk);
        chk({tag, "_ack_one_cycle"}, 32'(ack), 0);
        chk({tag, "_result_held"}, result, exp_res);
    endtask

    initial begin
        int          starts;
        int          cyc;
        logic        ok;
        logic [31:0] cont_res [4];
        cont_res = '{32'd1, 32'd2, 32'd6, 32'd24};

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        n_flat = 16'h0500;
        req    = 4'b0100;
        job("single_n5", 4'b0100, 32'd120, 2'd2, 1);
        chk("single_busy_after", 32'(busy), 0);

        n_flat = 16'h0000;
        req    = 4'b0001;
        job("edge_n0", 4'b0001, 32'd1, 2'd0, 1);
        n_flat = 16'h0001;
        req    = 4'b0001;
        job("edge_n1", 4'b0001, 32'd1, 2'd0, 1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        n_flat = 16'h4321;
        req    = 4'b1111;
        for (int k = 0; k < 4; k++)
            job($sformatf("contend%0d", k), 4'(1 << k), cont_res[k], 2'(k), -1);

        n_flat = 16'h3020;
        req    = 4'b1010;
        job("wrap_first", 4'b0010, 32'd2, 2'd1, -1);
        job("wrap_second", 4'b1000, 32'd6, 2'd3, -1);

        n_flat = 16'h0040;
        req    = 4'b0010;
        @(negedge clk);
        chk("immediate_grant_busy", 32'(busy), 1);
        chk("immediate_grant_start", 32'(core_start), 1);
        chk("immediate_grant_core_n", 32'(core_n), 4);
        job("immediate", 4'b0010, 32'd24, 2'd1, 0);

        n_flat = 16'h0007;
        req    = 4'b0001;
        repeat (6) @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        chk("pre_reset_core_n", 32'(core_n), 7);
        rst = 1'b1;
        #1;
        check_zero("async_reset");
        req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("reset_no_ack", 32'(ack), 0);
        rst = 1'b0;
        n_flat = 16'h0003;
        req    = 4'b0001;
        job("after_reset", 4'b0001, 32'd6, 2'd0, 1);

`ifdef FACT_SCHED_TIMEOUT_EN
        hang   = 1'b1;
        n_flat = 16'h0005;
        req    = 4'b0001;
        wait_ack(200, starts, cyc, ok);
        chk("tmo_ack_seen", 32'(ok), 1);
        chk("tmo_ack", 32'(ack), 32'b0001);
        chk("tmo_err", 32'(err), 1);
        chk("tmo_result", result, 0);
        chk("tmo_latency", 32'(cyc), 12);
        req = 4'b0000;
        @(negedge clk);
        chk("tmo_err_pulse", 32'(err), 0);
        rst  = 1'b1;
        hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`else
        starts = 0;
        cyc    = 0;
        ok     = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fact_scheduler.md
Name: fact_scheduler

Overview:
- Round-robin scheduler that shares one N-factorial datapath/controller pair (the "core") between NREQ requesters.
- It latches each requester's N, drives the core's start/done handshake, captures the result and returns it to the granted requester with a one-cycle ack.
- It sits between client blocks and the core. The core's start, N and done pins connect only to this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester index; must satisfy 2**IDW >= NREQ.
- NW, 4, width of N operand.
- FW, 32, width of factorial result.
- TIMEOUT, 255, watchdog limit in cycles. Used only with FACT_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until ack.
- n_flat  in  NREQ*NW  packed operands; requester i uses bits [i*NW +: NW].
- ack  out  NREQ  one-hot, one-cycle completion pulse.
- result  out  FW  factorial result; valid while ack is high, held afterwards.
- res_id  out  IDW  index of the requester whose result is on result.
- err  out  1  timeout flag, pulses with ack. Tied 0 when feature is off.
- busy  out  1  high in every state except IDLE.
- core_start  out  1  start to core.
- core_n  out  NW  operand to core; stable from ISSUE until RESP.
- core_done  in  1  core done level; high when core is idle.
- core_result  in  FW  core factorial output.

Behaviour:
- Reset (async, rst=1): state=IDLE, ptr=0. ack, result, res_id, err, core_start, core_n and busy are all 0.
- A reset mid-job abandons the job with no ack. The core shares rst.
- State IDLE:
  - If any req bit is high, grant the first index g at or after ptr, searching upward and wrapping modulo NREQ.
  - At the clock edge: latch cur_id=g, latch core_n=n_flat[g], set ptr=(g+1) mod NREQ, go to ISSUE.
  - With no requests, stay in IDLE.
- State ISSUE: core_start=1 for exactly one cycle, then go to WAIT_BUSY.
- State WAIT_BUSY: core_start=0.
  - If core_done=0, go to WAIT_DONE.
  - Otherwise stay.
- State WAIT_DONE: wait for core_done=1.
  - On the edge where it is seen high: capture result=core_result and res_id=cur_id, then go to RESP.
- State RESP: ack[cur_id]=1 for one cycle, then go to IDLE.
- Requesters must drop req on the edge that ends their ack cycle. A req still high in the following IDLE cycle counts as a new job.
- Latency: best case is grant edge + ISSUE + WAIT_BUSY + core compute + RESP. ack arrives 4 cycles plus core compute cycles after req is first sampled.
- Fairness: a continuously requesting client waits at most NREQ-1 other jobs.
- req changes outside IDLE are ignored until the next IDLE. n_flat is sampled only on the grant edge.
- core_start is never asserted while core_done=0 from a previous job.

Optional Feature:
- Macro: FACT_SCHED_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_BUSY and increments each cycle in WAIT_BUSY or WAIT_DONE.
  - On reaching TIMEOUT, go to RESP with result=0, err=1 and ack[cur_id]=1.
  - err=0 on normal completion.
- When undefined: no counter, err is constant 0, and the block waits indefinitely.

Test Plan:
- Single request: req[2]=1, n=5 -> one ack[2] pulse, result=120, res_id=2, err=0, busy falls the cycle after ack.
- Edge operands: n=0, then n=1 from req[0] -> result=1 both times. core_start is exactly one cycle wide each job.
- Contention: req=4'b1111 held with n=1,2,3,4, each requester dropping req after its ack -> acks in order 0,1,2,3, results 1,2,6,24.
- Round-robin wrap: after a job for requester 3 (ptr=0), assert req=4'b1010 -> grant 1 then 3. Then assert only req[1] -> granted immediately.
- Async reset during WAIT_DONE: pulse rst -> all outputs 0 at once, no ack. A new req[0] with n=3 then returns 6.
- With FACT_SCHED_TIMEOUT_EN and TIMEOUT=10, hold core_done=0 -> ack pulses with err=1 and result=0 after 10 waiting cycles.
